// File: rtl/mult_issue_queue_if.sv
// Shared entry format for the multiply/divide issue queues, and the bundle of
// dispatch, CDB and issue signals that connects a queue to its neighbours.
package mult_issue_queue_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  rd_tag;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs1_data_valid;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
        logic              rs2_data_valid;
    } common_fifo_data;
endpackage

interface mult_issue_queue_if #(parameter int DEPTH = 4);
    import mult_issue_queue_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              dispatch_en;
    common_fifo_data   i_fifo_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_ready;
    logic              issue_valid;
    common_fifo_data   o_issue_data;

    modport master (
        output flush, dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  full, empty, count, issue_valid, o_issue_data
    );

    modport slave (
        input  flush, dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, issue_ready,
        output full, empty, count, issue_valid, o_issue_data
    );
endinterface

// File: rtl/mult_issue_queue.sv
// In-order issue queue for the multiply (or divide) unit: holds dispatched ops,
// wakes waiting operands from the CDB and issues the head once it is ready.
module mult_issue_queue
    import mult_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    mult_issue_queue_if.slave q
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    common_fifo_data  mem [DEPTH];
    common_fifo_data  head_entry;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             issue_valid;

    // Capture a CDB result into any operand still waiting on the broadcast tag.
    function automatic common_fifo_data snoop(
        input common_fifo_data   e,
        input logic              v,
        input logic [TAG_W-1:0]  t,
        input logic [DATA_W-1:0] d
    );
        common_fifo_data r;
        r = e;
        if (v && !e.rs1_data_valid && (e.rs1_tag == t)) begin
            r.rs1_data       = d;
            r.rs1_data_valid = 1'b1;
        end
        if (v && !e.rs2_data_valid && (e.rs2_tag == t)) begin
            r.rs2_data       = d;
            r.rs2_data_valid = 1'b1;
        end
        return r;
    endfunction

    assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    assign empty = (head == tail);
    assign push  = q.dispatch_en && !full;
    assign pop   = issue_valid && q.issue_ready;

    assign head_entry  = mem[head[IDX_W-1:0]];
    assign issue_valid = !empty && head_entry.rs1_data_valid && head_entry.rs2_data_valid;

    assign q.full         = full;
    assign q.empty        = empty;
    assign q.count        = tail - head;
    assign q.issue_valid  = issue_valid;
    assign q.o_issue_data = empty ? '0 : head_entry;

    // Occupancy lives entirely in the pointers, so flush/reset need not touch storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (q.flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    // The slot being written this cycle is snooped too, so a same-cycle CDB hit is not lost.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail[IDX_W-1:0] == IDX_W'(i)))
                mem[i] <= snoop(q.i_fifo_data, q.cdb_valid, q.cdb_tag, q.cdb_data);
            else
                mem[i] <= snoop(mem[i], q.cdb_valid, q.cdb_tag, q.cdb_data);
        end
    end
endmodule

// File: tb/tb_mult_issue_queue.sv
// Randomized plus directed bench for mult_issue_queue, checked by a queue-based
// reference model and a monitor that scores every issued op.
module tb_mult_issue_queue;
    import mult_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_issue_queue_if #(.DEPTH(DEPTH)) q ();

    mult_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .q  (q.slave)
    );

    common_fifo_data model_q[$];
    int  chk = 0;
    int  err = 0;
    bit  popped = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic common_fifo_data wake(input common_fifo_data e, input bit v,
                                             input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        common_fifo_data r = e;
        if (v && !r.rs1_data_valid && r.rs1_tag == t) begin
            r.rs1_data = d; r.rs1_data_valid = 1'b1;
        end
        if (v && !r.rs2_data_valid && r.rs2_tag == t) begin
            r.rs2_data = d; r.rs2_data_valid = 1'b1;
        end
        return r;
    endfunction

    function automatic common_fifo_data mk(input int rd, input int t1, input int d1, input bit v1,
                                           input int t2, input int d2, input bit v2);
        common_fifo_data e;
        e.rd_tag = TAG_W'(rd);
        e.rs1_tag = TAG_W'(t1); e.rs1_data = DATA_W'(d1); e.rs1_data_valid = v1;
        e.rs2_tag = TAG_W'(t2); e.rs2_data = DATA_W'(d2); e.rs2_data_valid = v2;
        return e;
    endfunction

    // Reference model: a plain list of waiting ops, updated once per clock edge.
    always @(posedge clk) begin
        if (rst || q.flush) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < model_q.size(); i++)
                model_q[i] = wake(model_q[i], q.cdb_valid, q.cdb_tag, q.cdb_data);
            if (q.dispatch_en && (model_q.size() + int'(popped)) < DEPTH)
                model_q.push_back(wake(q.i_fifo_data, q.cdb_valid, q.cdb_tag, q.cdb_data));
        end
    end

    // Monitor: compare status every cycle, pop and score whenever the DUT issues.
    always @(negedge clk) begin
        bit exp_valid;
        common_fifo_data exp_e;
        popped = 0;
        if (rst) begin
            model_q.delete();
            check("rst_count", 96'(q.count), 96'(0));
            check("rst_empty", 96'(q.empty), 96'(1));
            check("rst_full", 96'(q.full), 96'(0));
            check("rst_issue_valid", 96'(q.issue_valid), 96'(0));
            check("rst_issue_data", 96'(q.o_issue_data), 96'(0));
        end else begin
            exp_valid = (model_q.size() > 0) && model_q[0].rs1_data_valid && model_q[0].rs2_data_valid;
            check("count", 96'(q.count), 96'(model_q.size()));
            check("empty", 96'(q.empty), 96'(model_q.size() == 0));
            check("full", 96'(q.full), 96'(model_q.size() == DEPTH));
            check("issue_valid", 96'(q.issue_valid), 96'(exp_valid));
            if (model_q.size() == 0)
                check("empty_issue_data", 96'(q.o_issue_data), 96'(0));
            if (q.issue_valid && q.issue_ready) begin
                if (model_q.size() == 0) begin
                    check("issue_unexpected", 96'(1), 96'(0));
                end else begin
                    exp_e = model_q.pop_front();
                    popped = 1;
                    check("issue_data", 96'(q.o_issue_data), 96'(exp_e));
                end
            end
        end
    end

    task automatic step(input bit disp, input common_fifo_data e, input bit cv, input int ct,
                        input int cd, input bit rdy, input bit fl);
        q.dispatch_en = disp;
        q.i_fifo_data = e;
        q.cdb_valid   = cv;
        q.cdb_tag     = TAG_W'(ct);
        q.cdb_data    = DATA_W'(cd);
        q.issue_ready = rdy;
        q.flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        rst = 1'b1;
        q.dispatch_en = 0; q.i_fifo_data = '0; q.cdb_valid = 0; q.cdb_tag = '0;
        q.cdb_data = '0; q.issue_ready = 0; q.flush = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ready op issues the cycle after dispatch
        step(1, mk(3, 0, 5, 1, 0, 7, 1), 0, 0, 0, 1, 0);
        idle(1, 2);
        // Operand woken by CDB one cycle after dispatch
        step(1, mk(1, 9, 0, 0, 0, 2, 1), 0, 0, 0, 1, 0);
        step(0, '0, 1, 9, 'h1234, 1, 0);
        idle(1, 2);
        // Fill, drop a fifth push, then drain in order
        for (int i = 0; i < 5; i++) step(1, mk(i, 0, 100 + i, 1, 0, 200 + i, 1), 0, 0, 0, 0, 0);
        idle(1, 6);
        // CDB hit in the same cycle as the push
        step(1, mk(4, 1, 1, 1, 12, 0, 0), 1, 12, 'hAA, 1, 0);
        idle(1, 2);
        // Blocked head holds back a ready younger op
        step(1, mk(5, 20, 0, 0, 0, 3, 1), 0, 0, 0, 0, 0);
        step(1, mk(6, 0, 8, 1, 0, 9, 1), 0, 0, 0, 0, 0);
        idle(1, 2);
        step(0, '0, 1, 20, 'h55, 1, 0);
        idle(1, 3);
        // Flush wins over simultaneous push and pop
        for (int i = 0; i < 3; i++) step(1, mk(i, 0, i, 1, 0, i, 1), 0, 0, 0, 0, 0);
        step(1, mk(7, 0, 1, 1, 0, 1, 1), 0, 0, 0, 1, 1);
        idle(1, 2);
        // Asynchronous reset in the middle of traffic
        step(1, mk(8, 2, 0, 0, 0, 1, 1), 0, 0, 0, 0, 0);
        step(1, mk(9, 0, 4, 1, 0, 4, 1), 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(0, 2);
        rst = 1'b0;
        idle(1, 2);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 6,
                 mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom, $urandom_range(0, 1),
                    $urandom_range(0, 7), $urandom, $urandom_range(0, 1)),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
        end
        idle(1, 4);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
